demod_sequencer: RTL and testbench

DEMOD_SEQUENCER -- requirements
Module: demod_sequencer

---
 rtl/demod_pkg.sv | 14 +
 rtl/chip_packer.sv | 60 ++++++
 rtl/demod_sequencer.sv | 124 ++++++++++++
 tb/tb_demod_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/demod_pkg.sv
// Shared definitions for the demod sequencer: FSM state encoding,
// chip word width and default configuration values.
package demod_pkg;
  localparam int CHIP_WORD_W     = 32;
  localparam int DEFAULT_DECIM   = 4;
  localparam int DEFAULT_TIMEOUT = 8;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_SAMPLE = 2'd1,
    ISSUE       = 2'd2,
    WAIT_DONE   = 2'd3
  } seq_state_e;
endpackage

// File: rtl/chip_packer.sv
// chip_packer: shifts CORDIC direction bits MSB-first into a chip word and
// presents completed words on a valid/ready output register.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   clear                synchronous restart (accumulator, count, valid, overflow)
//   bit_valid, bit_in    one direction bit to pack
//   word_ready           downstream accepts o_word this cycle
//   word, word_valid     completed chip word and its valid flag
//   overflow             sticky: a completed word was lost
module chip_packer
  import demod_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   bit_valid,
  input  logic                   bit_in,
  input  logic                   word_ready,
  output logic [CHIP_WORD_W-1:0] word,
  output logic                   word_valid,
  output logic                   overflow
);
  localparam int CW = $clog2(CHIP_WORD_W);

  logic [CHIP_WORD_W-1:0] acc, acc_next;
  logic [CW-1:0]          bit_cnt;
  logic                   last_bit;

  assign acc_next = {acc[CHIP_WORD_W-2:0], bit_in};
  assign last_bit = bit_valid && (bit_cnt == CW'(CHIP_WORD_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      bit_cnt    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      acc        <= '0;
      bit_cnt    <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (bit_valid) begin
        acc     <= last_bit ? '0 : acc_next;
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
      // A free slot, or one being emptied by this cycle's handshake, takes
      // the new word; otherwise the new word is lost and overflow sticks.
      if (last_bit && (!word_valid || word_ready)) begin
        word       <= acc_next;
        word_valid <= 1'b1;
      end else begin
        if (last_bit) overflow <= 1'b1;
        if (word_valid && word_ready) word_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/demod_sequencer.sv
// demod_sequencer: decimates an IQ sample stream, hands one selected sample
// at a time to a CORDIC demodulator and packs the returned direction bits
// into 32-bit chip words.
// Optional feature macro: DEMOD_SEQ_TIMEOUT_EN -- abandons a CORDIC request
// after TIMEOUT cycles in WAIT_DONE and pulses o_timeout; without it the
// sequencer waits for done indefinitely and o_timeout is tied low.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_clear                         synchronous soft restart (highest priority)
//   i_sample_valid, i_I, i_Q        input sample strobe and 4-bit IQ
//   o_cordic_enable                 one-cycle CORDIC start pulse
//   o_cordic_I, o_cordic_Q          sample held for the CORDIC
//   i_cordic_done, i_cordic_dir     CORDIC completion and direction bit
//   o_word, o_word_valid, i_word_ready  packed chip word handshake
//   o_drop                          selected sample discarded (CORDIC busy)
//   o_overflow                      sticky: completed word lost
//   o_timeout                       one-cycle CORDIC timeout pulse
//   o_busy                          high in ISSUE / WAIT_DONE
module demod_sequencer
  import demod_pkg::*;
#(
  parameter int DECIM   = DEFAULT_DECIM,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_sample_valid,
  input  logic [3:0]  i_I,
  input  logic [3:0]  i_Q,
  output logic        o_cordic_enable,
  output logic [3:0]  o_cordic_I,
  output logic [3:0]  o_cordic_Q,
  input  logic        i_cordic_done,
  input  logic        i_cordic_dir,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  input  logic        i_word_ready,
  output logic        o_drop,
  output logic        o_overflow,
  output logic        o_timeout,
  output logic        o_busy
);
  seq_state_e state, state_next;
  logic [3:0] dec_cnt;
  logic       sel, tmo_hit, in_flight;

  assign sel       = i_sample_valid && (dec_cnt == 4'd0);
  assign in_flight = (state == ISSUE) || (state == WAIT_DONE);

  // Decimation runs in every state so selection phase is independent of
  // whether the CORDIC is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              dec_cnt <= '0;
    else if (i_clear)        dec_cnt <= '0;
    else if (i_sample_valid) dec_cnt <= (dec_cnt == 4'(DECIM - 1)) ? 4'd0 : dec_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cordic_I <= '0;
      o_cordic_Q <= '0;
    end else if (!i_clear && (state == WAIT_SAMPLE) && sel) begin
      o_cordic_I <= i_I;
      o_cordic_Q <= i_Q;
    end
  end

`ifdef DEMOD_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            tmo_cnt <= '0;
    else if (i_clear || state != WAIT_DONE) tmo_cnt <= '0;
    else                                   tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == WAIT_DONE) && !i_cordic_done && (tmo_cnt == TW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo_hit        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:        state_next = WAIT_SAMPLE;
      WAIT_SAMPLE: if (sel) state_next = ISSUE;
      ISSUE:       state_next = WAIT_DONE;
      WAIT_DONE:   if (i_cordic_done || tmo_hit) state_next = WAIT_SAMPLE;
      default:     state_next = IDLE;
    endcase
    if (i_clear) state_next = IDLE;
  end

  // Outputs
  always_comb begin
    o_busy          = in_flight;
    o_cordic_enable = (state == ISSUE) && !i_clear;
    o_drop          = sel && in_flight && !i_clear;
    o_timeout       = tmo_hit && !i_clear;
  end

  chip_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (i_clear),
    .bit_valid  ((state == WAIT_DONE) && i_cordic_done),
    .bit_in     (i_cordic_dir),
    .word_ready (i_word_ready),
    .word       (o_word),
    .word_valid (o_word_valid),
    .overflow   (o_overflow)
  );
endmodule

// File: tb/tb_demod_sequencer.sv
// Directed self-checking bench for demod_sequencer (DECIM=4, TIMEOUT=8).
// Inputs change 1ns after the rising edge; combinational outputs are sampled
// on the falling edge.
module tb_demod_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, i_clear, i_sample_valid, i_cordic_done, i_cordic_dir, i_word_ready;
  logic [3:0]  i_I, i_Q;
  logic        o_cordic_enable, o_word_valid, o_drop, o_overflow, o_timeout, o_busy;
  logic [3:0]  o_cordic_I, o_cordic_Q;
  logic [31:0] o_word;

  demod_sequencer #(.DECIM(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_clear(i_clear),
    .i_sample_valid(i_sample_valid), .i_I(i_I), .i_Q(i_Q),
    .o_cordic_enable(o_cordic_enable), .o_cordic_I(o_cordic_I), .o_cordic_Q(o_cordic_Q),
    .i_cordic_done(i_cordic_done), .i_cordic_dir(i_cordic_dir),
    .o_word(o_word), .o_word_valid(o_word_valid), .i_word_ready(i_word_ready),
    .o_drop(o_drop), .o_overflow(o_overflow), .o_timeout(o_timeout), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int en_cnt = 0, drop_cnt = 0, vld_cnt = 0;
  logic [31:0] last_word = '0;

  always @(negedge clk) begin
    if (o_cordic_enable) en_cnt++;
    if (o_drop)          drop_cnt++;
    if (o_word_valid) begin
      vld_cnt++;
      last_word = o_word;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic        drop_s, tmo_s;
  logic [31:0] w_after;
  logic        v_after, ov_after;

  // One clock: apply inputs, sample comb outputs mid-cycle, consume the edge.
  task automatic cyc(input logic v, input logic [3:0] ii, input logic [3:0] qq,
                     input logic d, input logic dir, input logic rdy);
    i_sample_valid = v; i_I = ii; i_Q = qq;
    i_cordic_done = d; i_cordic_dir = dir; i_word_ready = rdy;
    @(negedge clk);
    drop_s = o_drop;
    tmo_s  = o_timeout;
    @(posedge clk); #1;
  endtask

  // One packed bit with DECIM=4: select, issue, done, one spare sample.
  task automatic bit4(input logic dir, input logic rdy_base, input logic rdy_done);
    cyc(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, rdy_base);
    cyc(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, rdy_base);
    cyc(1'b1, 4'd1, 4'd2, 1'b1, dir,  rdy_done);
    w_after = o_word; v_after = o_word_valid; ov_after = o_overflow;
    cyc(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, rdy_base);
  endtask

  task automatic send_word(input logic [31:0] w, input logic rdy_base, input logic rdy_last);
    for (int b = 31; b >= 0; b--) bit4(w[b], rdy_base, (b == 0) ? rdy_last : rdy_base);
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    i_clear = 1'b0;
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base2, first;
    rst_n = 1'b0; i_clear = 1'b0; i_sample_valid = 1'b0; i_I = '0; i_Q = '0;
    i_cordic_done = 1'b0; i_cordic_dir = 1'b0; i_word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word", o_word, 32'h0);
    chk("rst_valid", {31'b0, o_word_valid}, 32'h0);
    chk("rst_en", {31'b0, o_cordic_enable}, 32'h0);
    chk("rst_iq", {24'b0, o_cordic_I, o_cordic_Q}, 32'h0);
    chk("rst_flags", {28'b0, o_busy, o_overflow, o_drop, o_timeout}, 32'h0);
    rst_n = 1'b1;
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);   // IDLE -> WAIT_SAMPLE

    // Decimation and issue timing: 8 samples, two selections
    base = en_cnt;
    cyc(1'b1, 4'd3, 4'hE, 1'b0, 1'b0, 1'b1);
    chk("issue1_en", {31'b0, o_cordic_enable}, 32'h1);
    chk("issue1_iq", {24'b0, o_cordic_I, o_cordic_Q}, 32'h3E);
    cyc(1'b1, 4'd5, 4'd6, 1'b0, 1'b0, 1'b1);
    chk("wait_busy_en", {30'b0, o_busy, o_cordic_enable}, 32'h2);
    chk("wait_iq_stable", {24'b0, o_cordic_I, o_cordic_Q}, 32'h3E);
    cyc(1'b1, 4'd5, 4'd6, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 4'd5, 4'd6, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 4'd7, 4'd1, 1'b0, 1'b0, 1'b1);
    chk("issue2_iq", {23'b0, o_cordic_enable, o_cordic_I, o_cordic_Q}, 32'h171);
    cyc(1'b1, 4'd5, 4'd6, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 4'd5, 4'd6, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 4'd5, 4'd6, 1'b0, 1'b0, 1'b1);
    chk("enable_count", en_cnt - base, 2);
    do_clear();

    // Full word with ready held high: valid for exactly one cycle
    base = vld_cnt;
    send_word(32'hA5A5F00F, 1'b1, 1'b1);
    chk("word_a5", w_after, 32'hA5A5F00F);
    chk("word_a5_seen", last_word, 32'hA5A5F00F);
    chk("word_a5_vld_cycles", vld_cnt - base, 1);

    // Selected sample while waiting for done -> drop, no extra enable
    base = drop_cnt; base2 = en_cnt;
    cyc(1'b1, 4'd2, 4'd2, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 4'd2, 4'd2, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 4'd2, 4'd2, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 4'd2, 4'd2, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1);
    chk("drop_pulse", {31'b0, drop_s}, 32'h1);
    chk("drop_iq_kept", {24'b0, o_cordic_I, o_cordic_Q}, 32'h22);
    cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1);
    chk("drop_next", {31'b0, drop_s}, 32'h0);
    chk("drop_count", drop_cnt - base, 1);
    chk("drop_no_enable", en_cnt - base2, 1);
    chk("drop_idle", {31'b0, o_busy}, 32'h0);
    do_clear();

    // Two words with ready low: first kept, overflow set; clear drops both
    send_word(32'hDEADBEEF, 1'b0, 1'b0);
    chk("ovf_w1", {ov_after, v_after, w_after[29:0]}, {2'b01, 30'h1EADBEEF});
    send_word(32'h0F0F1234, 1'b0, 1'b0);
    chk("ovf_w2_word", w_after, 32'hDEADBEEF);
    chk("ovf_w2_flags", {30'b0, ov_after, v_after}, 32'h3);
    do_clear();
    chk("clear_flags", {30'b0, o_overflow, o_word_valid}, 32'h0);

    // Completion coinciding with a handshake loads the new word
    send_word(32'hDEADBEEF, 1'b0, 1'b0);
    send_word(32'h0F0F1234, 1'b0, 1'b1);
    chk("hs_word", w_after, 32'h0F0F1234);
    chk("hs_flags", {30'b0, ov_after, v_after}, 32'h1);
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("hs_release", {31'b0, o_word_valid}, 32'h0);
    do_clear();

    // Reset in WAIT_DONE after 17 bits
    for (int k = 0; k < 17; k++) bit4(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 4'd6, 4'd6, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 4'd6, 4'd6, 1'b0, 1'b0, 1'b1);
    chk("pre_rst_busy", {31'b0, o_busy}, 32'h1);
    #2 rst_n = 1'b0;
    i_sample_valid = 1'b1;
    #1;
    chk("mid_rst_outs", {24'b0, o_cordic_I, o_cordic_Q}, 32'h0);
    chk("mid_rst_word", o_word, 32'h0);
    chk("mid_rst_flags", {26'b0, o_busy, o_cordic_enable, o_word_valid, o_overflow, o_drop, o_timeout}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    base = vld_cnt;
    for (int b = 31; b >= 1; b--) bit4(1'b1, 1'b1, 1'b1);
    chk("post_rst_31bits", vld_cnt - base, 0);
    bit4(1'b0, 1'b1, 1'b1);
    chk("post_rst_word", {31'b0, v_after} ^ {w_after[31:1], 1'b0}, 32'hFFFFFFFF);
    do_clear();

    // Done never returned
    first = -1;
    cyc(1'b1, 4'd4, 4'd4, 1'b0, 1'b0, 1'b1);   // now in ISSUE (cycle 0)
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      if (tmo_s && first < 0) first = k;
    end
`ifdef DEMOD_SEQ_TIMEOUT_EN
    chk("timeout_cycle", first, 8);
    chk("timeout_idle", {31'b0, o_busy}, 32'h0);
    repeat (3) cyc(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    base = vld_cnt;
    for (int b = 31; b >= 1; b--) bit4(1'b0, 1'b1, 1'b1);
    chk("timeout_no_bit", vld_cnt - base, 0);
    bit4(1'b1, 1'b1, 1'b1);
    chk("timeout_word", {31'b0, v_after} ^ w_after, 32'h0);
`else
    chk("no_timeout", first, 32'hFFFFFFFF);
    chk("no_timeout_busy", {31'b0, o_busy}, 32'h1);
    cyc(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1);
    chk("no_timeout_done", {31'b0, o_busy}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
